// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller.
// Forward selects and controller state values.
package hazard_fwd_ctrl_pkg;

  localparam int GPR_ADR = 5;

  localparam logic [1:0] RSF_RSF = 2'b00;
  localparam logic [1:0] RSF_WBD = 2'b01;
  localparam logic [1:0] RSF_ALU = 2'b10;

  localparam logic [1:0] RTF_RTF = 2'b00;
  localparam logic [1:0] RTF_WBD = 2'b01;
  localparam logic [1:0] RTF_ALU = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_LSTALL = 2'd1,
    HZ_FLUSH  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hz_slot_cmp.sv
// Slot-versus-operand hit comparator.
// Register 0 never produces a hit.
module hz_slot_cmp #(
  parameter int GPR_ADR = 5
) (
  input  logic               valid,
  input  logic               reg_write,
  input  logic [GPR_ADR-1:0] addr,
  input  logic [GPR_ADR-1:0] op_addr,
  input  logic               uses,
  output logic               hit
);

  assign hit = valid & reg_write & uses &
               (addr != '0) & (addr == op_addr);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Shadows EX/MEM destinations; drives forward selects and stalls.
module hazard_fwd_ctrl #(
  parameter int GPR_ADR = 5,
  parameter int CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [GPR_ADR-1:0] id_rs_addr,
  input  logic [GPR_ADR-1:0] id_rt_addr,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic [GPR_ADR-1:0] id_write_reg_addr,
  input  logic               branch_taken,
  input  logic               mem_busy,
  output logic [1:0]         rs_forward,
  output logic [1:0]         rt_forward,
  output logic               cen_front,
  output logic               cen_ex,
  output logic               bubble,
  output logic               flush_if_id,
  output logic [CNT_BIT-1:0] stall_count
);
  import hazard_fwd_ctrl_pkg::*;

  typedef struct packed {
    logic               valid;
    logic [GPR_ADR-1:0] addr;
    logic               reg_write;
    logic               mem_to_reg;
  } ex_slot_t;

  typedef struct packed {
    logic               valid;
    logic [GPR_ADR-1:0] addr;
    logic               reg_write;
  } mem_slot_t;

  ex_slot_t  ex_slot;
  mem_slot_t mem_slot;
  hz_state_t state;
  hz_state_t state_nxt;

  logic ex_rs_hit;
  logic ex_rt_hit;
  logic mem_rs_hit;
  logic mem_rt_hit;
  logic load_use;
  logic [1:0] rs_sel;
  logic [1:0] rt_sel;

  hz_slot_cmp #(.GPR_ADR(GPR_ADR)) u_ex_rs (
    .valid(ex_slot.valid), .reg_write(ex_slot.reg_write),
    .addr(ex_slot.addr), .op_addr(id_rs_addr),
    .uses(id_uses_rs), .hit(ex_rs_hit)
  );

  hz_slot_cmp #(.GPR_ADR(GPR_ADR)) u_ex_rt (
    .valid(ex_slot.valid), .reg_write(ex_slot.reg_write),
    .addr(ex_slot.addr), .op_addr(id_rt_addr),
    .uses(id_uses_rt), .hit(ex_rt_hit)
  );

  hz_slot_cmp #(.GPR_ADR(GPR_ADR)) u_mem_rs (
    .valid(mem_slot.valid), .reg_write(mem_slot.reg_write),
    .addr(mem_slot.addr), .op_addr(id_rs_addr),
    .uses(id_uses_rs), .hit(mem_rs_hit)
  );

  hz_slot_cmp #(.GPR_ADR(GPR_ADR)) u_mem_rt (
    .valid(mem_slot.valid), .reg_write(mem_slot.reg_write),
    .addr(mem_slot.addr), .op_addr(id_rt_addr),
    .uses(id_uses_rt), .hit(mem_rt_hit)
  );

  assign load_use = ex_slot.mem_to_reg & (ex_rs_hit | ex_rt_hit);

  // Youngest producer (EX) wins over MEM.
  always_comb begin
    rs_sel = RSF_RSF;
    if (ex_rs_hit & ~ex_slot.mem_to_reg) rs_sel = RSF_ALU;
    else if (mem_rs_hit)                 rs_sel = RSF_WBD;
  end

  always_comb begin
    rt_sel = RTF_RTF;
    if (ex_rt_hit & ~ex_slot.mem_to_reg) rt_sel = RTF_ALU;
    else if (mem_rt_hit)                 rt_sel = RTF_WBD;
  end

  always_comb begin
    cen_front   = 1'b1;
    cen_ex      = 1'b1;
    bubble      = 1'b0;
    flush_if_id = 1'b0;
    state_nxt   = HZ_RUN;
    if (mem_busy) begin
      cen_front = 1'b0;
      cen_ex    = 1'b0;
      state_nxt = state;
    end else begin
      unique case (state)
        HZ_FLUSH: bubble = 1'b1;
        default: begin
          if (branch_taken) begin
            flush_if_id = 1'b1;
            bubble      = 1'b1;
            state_nxt   = HZ_FLUSH;
          end else if (load_use) begin
            cen_front = 1'b0;
            bubble    = 1'b1;
            state_nxt = HZ_LSTALL;
          end
        end
      endcase
    end
  end

  assign rs_forward = (cen_ex & ~bubble) ? rs_sel : RSF_RSF;
  assign rt_forward = (cen_ex & ~bubble) ? rt_sel : RTF_RTF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HZ_RUN;
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      state <= state_nxt;
      if (cen_ex) begin
        mem_slot <= '{ex_slot.valid, ex_slot.addr,
                      ex_slot.reg_write};
        if (bubble | ~id_valid)
          ex_slot <= '0;
        else
          ex_slot <= '{1'b1, id_write_reg_addr,
                       id_reg_write, id_mem_to_reg};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if ((mem_busy | bubble | ~cen_front) & ~&stall_count)
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios plus a
// randomized run against a pipeline-occupancy reference model.
module tb_hazard_fwd_ctrl;
  localparam int AW = 5;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          id_reg_write;
  logic          id_mem_to_reg;
  logic [AW-1:0] id_write_reg_addr;
  logic          branch_taken;
  logic          mem_busy;
  logic [1:0]    rs_forward;
  logic [1:0]    rt_forward;
  logic          cen_front;
  logic          cen_ex;
  logic          bubble;
  logic          flush_if_id;
  logic [CB-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.GPR_ADR(AW), .CNT_BIT(CB)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_write_reg_addr(id_write_reg_addr),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .rs_forward(rs_forward), .rt_forward(rt_forward),
    .cen_front(cen_front), .cen_ex(cen_ex),
    .bubble(bubble), .flush_if_id(flush_if_id),
    .stall_count(stall_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the instructions now in EX and MEM, plus a mode.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
  } prod_t;

  typedef struct packed {
    logic [1:0] rsf;
    logic [1:0] rtf;
    logic       cf;
    logic       ce;
    logic       bub;
    logic       fl;
    logic [1:0] nmode;
  } exp_t;

  localparam logic [1:0] M_RUN = 2'd0;
  localparam logic [1:0] M_LS  = 2'd1;
  localparam logic [1:0] M_FL  = 2'd2;

  prod_t      m_ex  = '0;
  prod_t      m_mem = '0;
  logic [1:0] m_mode = M_RUN;
  int         m_cnt = 0;
  exp_t       m_now;

  function automatic logic m_hit(prod_t p, logic [AW-1:0] src,
                                 logic u);
    return p.v && p.wr && p.rd != 0 && p.rd == src && u;
  endfunction

  function automatic logic [1:0] m_sel(logic [AW-1:0] src, logic u);
    if (m_hit(m_ex, src, u) && !m_ex.ld) return 2'd2;
    if (m_hit(m_mem, src, u)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    logic lu;
    lu = m_ex.ld && (m_hit(m_ex, id_rs_addr, id_uses_rs) ||
                     m_hit(m_ex, id_rt_addr, id_uses_rt));
    e = '0;
    e.cf = 1'b1;
    e.ce = 1'b1;
    e.nmode = M_RUN;
    if (mem_busy) begin
      e.cf = 1'b0;
      e.ce = 1'b0;
      e.nmode = m_mode;
    end else if (m_mode == M_FL) begin
      e.bub = 1'b1;
    end else if (branch_taken) begin
      e.fl = 1'b1;
      e.bub = 1'b1;
      e.nmode = M_FL;
    end else if (lu) begin
      e.cf = 1'b0;
      e.bub = 1'b1;
      e.nmode = M_LS;
    end
    if (e.ce && !e.bub) begin
      e.rsf = m_sel(id_rs_addr, id_uses_rs);
      e.rtf = m_sel(id_rt_addr, id_uses_rt);
    end
    return e;
  endfunction

  always_comb m_now = model_eval();

  always @(posedge clk) begin
    if (rst) begin
      m_ex   <= '0;
      m_mem  <= '0;
      m_mode <= M_RUN;
      m_cnt  <= 0;
    end else begin
      if (m_now.ce) begin
        m_mem <= m_ex;
        if (m_now.bub || !id_valid) m_ex <= '0;
        else m_ex <= '{1'b1, id_write_reg_addr,
                       id_reg_write, id_mem_to_reg};
      end
      m_mode <= m_now.nmode;
      if ((mem_busy || m_now.bub || !m_now.cf) &&
          m_cnt < (1 << CB) - 1)
        m_cnt <= m_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(logic v, int rs, int rt, logic urs,
                        logic urt, logic rw, logic ld, int rd);
    id_valid          = v;
    id_rs_addr        = AW'(rs);
    id_rt_addr        = AW'(rt);
    id_uses_rs        = urs;
    id_uses_rt        = urt;
    id_reg_write      = rw;
    id_mem_to_reg     = ld;
    id_write_reg_addr = AW'(rd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    mem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id, rs_forward,
         rt_forward} !== 8'b1100_0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 11000000",
               {cen_front, cen_ex, bubble, flush_if_id,
                rs_forward, rt_forward});
    end
    n_cmp++;
    if (stall_count !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d want 0", stall_count);
    end
    tick();
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_id(1, 1, 2, 1, 1, 1, 0, 3);
    tick();
    set_id(1, 3, 5, 1, 1, 1, 0, 4);
    @(negedge clk);
    n_cmp++;
    if ({rs_forward, rt_forward} !== 4'b1000) begin
      n_bad++;
      $display("FAIL alu_chain_sel: got %b want 1000",
               {rs_forward, rt_forward});
    end
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id} !== 4'b1100 ||
        stall_count !== '0) begin
      n_bad++;
      $display("FAIL alu_chain_ctrl: got %b cnt %0d want 1100 cnt 0",
               {cen_front, cen_ex, bubble, flush_if_id}, stall_count);
    end
    tick();
  endtask

  task automatic test_gap_one();
    do_reset();
    set_id(1, 1, 2, 1, 1, 1, 0, 3);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 3, 3, 1, 1, 1, 0, 6);
    @(negedge clk);
    n_cmp++;
    if ({rs_forward, rt_forward} !== 4'b0101) begin
      n_bad++;
      $display("FAIL gap_one_sel: got %b want 0101",
               {rs_forward, rt_forward});
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 2, 0, 1, 0, 1, 1, 7);
    tick();
    set_id(1, 7, 1, 1, 1, 1, 0, 8);
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id, rs_forward,
         rt_forward} !== 8'b0110_0000) begin
      n_bad++;
      $display("FAIL load_use_stall: got %b want 01100000",
               {cen_front, cen_ex, bubble, flush_if_id,
                rs_forward, rt_forward});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id, rs_forward,
         rt_forward} !== 8'b1100_0100) begin
      n_bad++;
      $display("FAIL load_use_fwd: got %b want 11000100",
               {cen_front, cen_ex, bubble, flush_if_id,
                rs_forward, rt_forward});
    end
    n_cmp++;
    if (stall_count !== CB'(1)) begin
      n_bad++;
      $display("FAIL load_use_cnt: got %0d want 1", stall_count);
    end
    tick();
  endtask

  task automatic test_r0_writer();
    do_reset();
    set_id(1, 1, 2, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 1, 1, 1, 0, 4);
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id, rs_forward,
         rt_forward} !== 8'b1100_0000) begin
      n_bad++;
      $display("FAIL r0_writer: got %b want 11000000",
               {cen_front, cen_ex, bubble, flush_if_id,
                rs_forward, rt_forward});
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1, 1, 2, 1, 1, 1, 0, 3);
    branch_taken = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id} !== 4'b1111) begin
      n_bad++;
      $display("FAIL branch_c1: got %b want 1111",
               {cen_front, cen_ex, bubble, flush_if_id});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id} !== 4'b1110) begin
      n_bad++;
      $display("FAIL branch_flush: got %b want 1110",
               {cen_front, cen_ex, bubble, flush_if_id});
    end
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id} !== 4'b1100 ||
        stall_count !== CB'(2)) begin
      n_bad++;
      $display("FAIL branch_after: got %b cnt %0d want 1100 cnt 2",
               {cen_front, cen_ex, bubble, flush_if_id}, stall_count);
    end
    tick();
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_id(1, 2, 0, 1, 0, 1, 1, 7);
    tick();
    set_id(1, 7, 1, 1, 1, 1, 0, 8);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cen_front, cen_ex, bubble, flush_if_id, rs_forward,
           rt_forward} !== 8'b0000_0000) begin
        n_bad++;
        $display("FAIL busy_hold%0d: got %b want 00000000", i,
                 {cen_front, cen_ex, bubble, flush_if_id,
                  rs_forward, rt_forward});
      end
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id} !== 4'b0110 ||
        stall_count !== CB'(3)) begin
      n_bad++;
      $display("FAIL busy_release: got %b cnt %0d want 0110 cnt 3",
               {cen_front, cen_ex, bubble, flush_if_id}, stall_count);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (rs_forward !== 2'b01 || stall_count !== CB'(4)) begin
      n_bad++;
      $display("FAIL busy_done: got rs %b cnt %0d want rs 01 cnt 4",
               rs_forward, stall_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(1, 2, 0, 1, 0, 1, 1, 7);
    tick();
    set_id(1, 7, 7, 1, 1, 1, 0, 8);
    @(negedge clk);
    n_cmp++;
    if (bubble !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_pre: got bubble %b want 1", bubble);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cen_front, cen_ex, bubble, flush_if_id, rs_forward,
         rt_forward} !== 8'b1100_0000 || stall_count !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_post: got %b cnt %0d want 11000000 cnt 0",
               {cen_front, cen_ex, bubble, flush_if_id,
                rs_forward, rt_forward}, stall_count);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 99) < 85,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30,
             int'($urandom_range(0, 3)));
      branch_taken = $urandom_range(0, 99) < 10;
      mem_busy     = $urandom_range(0, 99) < 15;
      @(negedge clk);
      n_cmp++;
      if ({rs_forward, rt_forward, cen_front, cen_ex, bubble,
           flush_if_id} !== {m_now.rsf, m_now.rtf, m_now.cf,
           m_now.ce, m_now.bub, m_now.fl}) begin
        n_bad++;
        $display("FAIL rand_ctrl cyc %0d: got %b want %b", i,
                 {rs_forward, rt_forward, cen_front, cen_ex, bubble,
                  flush_if_id},
                 {m_now.rsf, m_now.rtf, m_now.cf, m_now.ce,
                  m_now.bub, m_now.fl});
      end
      n_cmp++;
      if (stall_count !== CB'(m_cnt)) begin
        n_bad++;
        $display("FAIL rand_cnt cyc %0d: got %0d want %0d", i,
                 stall_count, m_cnt);
      end
      tick();
    end
    branch_taken = 1'b0;
    mem_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    branch_taken = 1'b0;
    mem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    test_reset();
    test_alu_chain();
    test_gap_one();
    test_load_use();
    test_r0_writer();
    test_branch();
    test_mem_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
